// File: rtl/sdcard_ctrlmod_if.sv
// Bundle of signals between the SD command-level controller, its caller and
// the SD byte/command engine. The controller uses the master view. The caller
// and the engine together use the slave view.
interface sdcard_ctrlmod_if;
    logic [1:0]  iCall;   // [1] init request, [0] block-read request
    logic [31:0] iAddr;   // sector number for a read
    logic        oDone;   // one-cycle completion pulse
    logic        oErr;    // status of the last operation
    logic [7:0]  oData;   // read data byte
    logic        oEn;     // one-cycle strobe per data byte
    logic        SD_NCS;  // card chip select, active-low
    logic [1:0]  oFCall;  // engine call: [1] command frame, [0] single byte
    logic        iFDone;  // engine one-cycle done pulse
    logic [47:0] oFAddr;  // command frame {cmd, arg, crc}
    logic [7:0]  oFData;  // byte to transmit on a byte call
    logic [7:0]  iFData;  // R1 response or received byte

    modport master (
        input  iCall, iAddr, iFDone, iFData,
        output oDone, oErr, oData, oEn, SD_NCS, oFCall, oFAddr, oFData
    );

    modport slave (
        output iCall, iAddr, iFDone, iFData,
        input  oDone, oErr, oData, oEn, SD_NCS, oFCall, oFAddr, oFData
    );
endinterface

// File: rtl/sdcard_ctrlmod.sv
// SD (SPI mode) command-level controller. It runs card init (dummy clocks,
// CMD0, CMD1) and single-block reads (CMD17, token wait, data, CRC). It calls
// the byte/command engine through a call/done handshake and streams the read
// bytes out with a one-cycle strobe per byte.
module sdcard_ctrlmod #(
    parameter int DUMMY_BYTES = 10,
    parameter int CMD_RETRY   = 100,
    parameter int TOKEN_MAX   = 1000,
    parameter int BLOCK_LEN   = 512
) (
    input  logic              CLOCK,
    input  logic              RESET,
    sdcard_ctrlmod_if.master  bus
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_DUMMY = 4'd1;
    localparam logic [3:0] ST_CMD0  = 4'd2;
    localparam logic [3:0] ST_CMD1  = 4'd3;
    localparam logic [3:0] ST_CMD17 = 4'd4;
    localparam logic [3:0] ST_POLL  = 4'd5;
    localparam logic [3:0] ST_DATA  = 4'd6;
    localparam logic [3:0] ST_CRC   = 4'd7;
    localparam logic [3:0] ST_FIN   = 4'd8;
    localparam logic [3:0] ST_DONE  = 4'd9;

    localparam logic [1:0] CALL_NONE = 2'b00;
    localparam logic [1:0] CALL_BYTE = 2'b01;
    localparam logic [1:0] CALL_CMD  = 2'b10;

    // Terminal counts are compared directly, so the counters never wrap.
    localparam logic [9:0] DUMMY_LAST = 10'(DUMMY_BYTES - 1);
    localparam logic [9:0] BLOCK_LAST = 10'(BLOCK_LEN - 1);
    localparam logic [9:0] TOKEN_LAST = 10'(TOKEN_MAX - 1);
    localparam logic [6:0] RETRY_LAST = 7'(CMD_RETRY - 1);

    logic [3:0]  state_q, state_d;
    logic [1:0]  fcall_q, fcall_d;
    logic [47:0] faddr_q, faddr_d;
    logic        ncs_q, ncs_d;
    logic        done_q, done_d;
    logic        err_out_q, err_out_d;
    logic        err_q, err_d;
    logic [7:0]  data_q, data_d;
    logic        en_q, en_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic [9:0]  poll_cnt_q, poll_cnt_d;
    logic [6:0]  retry_cnt_q, retry_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        busy_s;
    logic        fdone_s;

    // An engine done pulse only counts while a call is outstanding.
    assign busy_s  = (fcall_q != CALL_NONE);
    assign fdone_s = bus.iFDone && busy_s;

    // Next-state logic: issue engine calls, consume the responses, step counters.
    always_comb begin
        state_d     = state_q;
        fcall_d     = fcall_q;
        faddr_d     = faddr_q;
        done_d      = 1'b0;
        err_out_d   = err_out_q;
        err_d       = err_q;
        data_d      = data_q;
        en_d        = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        retry_cnt_d = retry_cnt_q;
        addr_d      = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.iCall[1]) begin
                    state_d     = ST_DUMMY;
                    byte_cnt_d  = 10'd0;
                    retry_cnt_d = 7'd0;
                    err_out_d   = 1'b0;
                    err_d       = 1'b0;
                end else if (bus.iCall[0]) begin
                    state_d   = ST_CMD17;
                    addr_d    = bus.iAddr << 4'd9;
                    err_out_d = 1'b0;
                    err_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DUMMY: begin
                if (!busy_s) begin
                    fcall_d = CALL_BYTE;
                end else if (fdone_s) begin
                    fcall_d = CALL_NONE;
                    if (byte_cnt_q == DUMMY_LAST) begin
                        state_d     = ST_CMD0;
                        byte_cnt_d  = 10'd0;
                        retry_cnt_d = 7'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                end else begin
                    fcall_d = fcall_q;
                end
            end

            ST_CMD0: begin
                if (!busy_s) begin
                    fcall_d = CALL_CMD;
                    faddr_d = {8'h40, 32'h0000_0000, 8'h95};
                end else if (fdone_s) begin
                    fcall_d = CALL_NONE;
                    if (bus.iFData == 8'h01) begin
                        state_d     = ST_CMD1;
                        retry_cnt_d = 7'd0;
                    end else if (retry_cnt_q == RETRY_LAST) begin
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 7'd1;
                    end
                end else begin
                    fcall_d = fcall_q;
                end
            end

            ST_CMD1: begin
                if (!busy_s) begin
                    fcall_d = CALL_CMD;
                    faddr_d = {8'h41, 32'h0000_0000, 8'hFF};
                end else if (fdone_s) begin
                    fcall_d = CALL_NONE;
                    if (bus.iFData == 8'h00) begin
                        state_d = ST_FIN;
                    end else if (retry_cnt_q == RETRY_LAST) begin
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 7'd1;
                    end
                end else begin
                    fcall_d = fcall_q;
                end
            end

            ST_CMD17: begin
                if (!busy_s) begin
                    fcall_d = CALL_CMD;
                    faddr_d = {8'h51, addr_q, 8'hFF};
                end else if (fdone_s) begin
                    fcall_d = CALL_NONE;
                    if (bus.iFData == 8'h00) begin
                        state_d    = ST_POLL;
                        poll_cnt_d = 10'd0;
                    end else begin
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end
                end else begin
                    fcall_d = fcall_q;
                end
            end

            ST_POLL: begin
                if (!busy_s) begin
                    fcall_d = CALL_BYTE;
                end else if (fdone_s) begin
                    fcall_d = CALL_NONE;
                    if (bus.iFData == 8'hFE) begin
                        state_d    = ST_DATA;
                        byte_cnt_d = 10'd0;
                    end else if (poll_cnt_q == TOKEN_LAST) begin
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 10'd1;
                    end
                end else begin
                    fcall_d = fcall_q;
                end
            end

            ST_DATA: begin
                if (!busy_s) begin
                    fcall_d = CALL_BYTE;
                end else if (fdone_s) begin
                    fcall_d = CALL_NONE;
                    data_d  = bus.iFData;
                    en_d    = 1'b1;
                    if (byte_cnt_q == BLOCK_LAST) begin
                        state_d    = ST_CRC;
                        byte_cnt_d = 10'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                end else begin
                    fcall_d = fcall_q;
                end
            end

            ST_CRC: begin
                if (!busy_s) begin
                    fcall_d = CALL_BYTE;
                end else if (fdone_s) begin
                    fcall_d = CALL_NONE;
                    if (byte_cnt_q == 10'd1) begin
                        state_d    = ST_FIN;
                        byte_cnt_d = 10'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                end else begin
                    fcall_d = fcall_q;
                end
            end

            ST_FIN: begin
                if (!busy_s) begin
                    fcall_d = CALL_BYTE;
                end else if (fdone_s) begin
                    fcall_d   = CALL_NONE;
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    err_out_d = err_q;
                end else begin
                    fcall_d = fcall_q;
                end
            end

            // oDone is high for this one cycle. Holding off the return to
            // IDLE lets the caller drop iCall first.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                fcall_d = CALL_NONE;
            end
        endcase
    end

    // The card is selected only in the states that talk to it.
    always_comb begin
        case (state_d)
            ST_CMD0, ST_CMD1, ST_CMD17, ST_POLL, ST_DATA, ST_CRC: ncs_d = 1'b0;
            default:                                              ncs_d = 1'b1;
        endcase
    end

    // State and output registers. Reset returns everything to idle with the card deselected.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            fcall_q     <= 2'b00;
            faddr_q     <= 48'h0;
            ncs_q       <= 1'b1;
            done_q      <= 1'b0;
            err_out_q   <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= 8'h00;
            en_q        <= 1'b0;
            byte_cnt_q  <= 10'd0;
            poll_cnt_q  <= 10'd0;
            retry_cnt_q <= 7'd0;
            addr_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            fcall_q     <= fcall_d;
            faddr_q     <= faddr_d;
            ncs_q       <= ncs_d;
            done_q      <= done_d;
            err_out_q   <= err_out_d;
            err_q       <= err_d;
            data_q      <= data_d;
            en_q        <= en_d;
            byte_cnt_q  <= byte_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            addr_q      <= addr_d;
        end
    end

    assign bus.oFCall = fcall_q;
    assign bus.oFAddr = faddr_q;
    assign bus.oFData = 8'hFF;
    assign bus.SD_NCS = ncs_q;
    assign bus.oDone  = done_q;
    assign bus.oErr   = err_out_q;
    assign bus.oData  = data_q;
    assign bus.oEn    = en_q;

endmodule

// File: tb/tb_sdcard_ctrlmod.sv
// Bench for sdcard_ctrlmod. A behavioural engine+card model answers the
// engine calls. The expected data bytes and completion status go into queues.
// They are popped and compared when the controller produces oEn and oDone.
module tb_sdcard_ctrlmod;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    sdcard_ctrlmod_if sd_if();

    sdcard_ctrlmod #(
        .DUMMY_BYTES(10),
        .CMD_RETRY  (100),
        .TOKEN_MAX  (1000),
        .BLOCK_LEN  (512)
    ) dut (
        .CLOCK(clk),
        .RESET(rst),
        .bus  (sd_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard queues
    logic [7:0] exp_data_q[$];
    logic       exp_err_q[$];

    // Card behaviour knobs
    bit         cmd0_ff;
    logic [7:0] cmd1_seq[$];
    logic [7:0] r17;
    int         token_after;

    // Model state and observation counters
    int          phase;
    int          didx;
    int          n_hi_bytes, n_cmd0, n_cmd1, n_cmd17, n_polls, n_crc;
    int          n_en, n_done, n_cmd_ncs_hi, hi_before_cmd0;
    logic [47:0] last_faddr;
    logic [7:0]  first_cmd;
    bit          seen_cmd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_hi_bytes = 0; n_cmd0 = 0; n_cmd1 = 0; n_cmd17 = 0; n_polls = 0;
        n_crc = 0; n_en = 0; n_cmd_ncs_hi = 0; hi_before_cmd0 = -1;
        seen_cmd = 1'b0; first_cmd = 8'h00; last_faddr = 48'h0; phase = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_fcall", 64'(sd_if.oFCall), 64'd0);
        chk("rst_faddr", 64'(sd_if.oFAddr), 64'd0);
        chk("rst_fdata", 64'(sd_if.oFData), 64'hFF);
        chk("rst_ncs",   64'(sd_if.SD_NCS), 64'd1);
        chk("rst_done",  64'(sd_if.oDone),  64'd0);
        chk("rst_err",   64'(sd_if.oErr),   64'd0);
        chk("rst_data",  64'(sd_if.oData),  64'd0);
        chk("rst_en",    64'(sd_if.oEn),    64'd0);
    endtask

    // Behavioural engine+card: serve one call, answer with a one-cycle done pulse.
    initial begin : engine
        logic [1:0]  call;
        logic [47:0] fa;
        logic        ncs;
        logic [7:0]  resp;
        sd_if.iFDone = 1'b0;
        sd_if.iFData = 8'hFF;
        forever begin
            @(negedge clk);
            if (!rst && sd_if.oFCall != 2'b00) begin
                call = sd_if.oFCall;
                fa   = sd_if.oFAddr;
                ncs  = sd_if.SD_NCS;
                chk("fcall_exclusive", 64'(call == 2'b11), 64'd0);
                resp = 8'hFF;
                if (call[1]) begin
                    if (ncs) n_cmd_ncs_hi++;
                    if (!seen_cmd) begin
                        seen_cmd       = 1'b1;
                        first_cmd      = fa[47:40];
                        hi_before_cmd0 = n_hi_bytes;
                    end
                    case (fa[47:40])
                        8'h40: begin
                            n_cmd0++;
                            resp = cmd0_ff ? 8'hFF : 8'h01;
                        end
                        8'h41: begin
                            n_cmd1++;
                            if (cmd1_seq.size() > 0) resp = cmd1_seq.pop_front();
                            else                     resp = 8'h00;
                        end
                        8'h51: begin
                            n_cmd17++;
                            last_faddr = fa;
                            resp       = r17;
                            if (r17 == 8'h00) phase = 1;
                        end
                        default: resp = 8'hFF;
                    endcase
                end else if (ncs) begin
                    n_hi_bytes++;
                    phase = 0;
                end else begin
                    case (phase)
                        1: begin
                            n_polls++;
                            if (token_after >= 0 && n_polls > token_after) begin
                                resp  = 8'hFE;
                                phase = 2;
                                didx  = 0;
                            end
                        end
                        2: begin
                            resp = didx[7:0];
                            exp_data_q.push_back(didx[7:0]);
                            didx++;
                            if (didx == 512) phase = 3;
                        end
                        3: begin
                            n_crc++;
                            resp = 8'hA5;
                        end
                        default: resp = 8'hFF;
                    endcase
                end
                @(negedge clk);
                if (!rst) begin
                    sd_if.iFData = resp;
                    sd_if.iFDone = 1'b1;
                    @(negedge clk);
                end
                sd_if.iFDone = 1'b0;
            end
        end
    end

    // Output monitor: pop the scoreboard on each data strobe and each completion.
    initial begin : monitor
        logic [8:0] ed;
        logic [1:0] ee;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sd_if.oEn) begin
                    n_en++;
                    ed = (exp_data_q.size() > 0) ? {1'b0, exp_data_q.pop_front()} : 9'h100;
                    chk("data_byte", 64'({1'b0, sd_if.oData}), 64'(ed));
                end
                if (sd_if.oDone) begin
                    n_done++;
                    ee = (exp_err_q.size() > 0) ? {1'b0, exp_err_q.pop_front()} : 2'b10;
                    chk("done_err", 64'({1'b0, sd_if.oErr}), 64'(ee));
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] call, input logic [31:0] addr, input logic exp_err);
        bit ok;
        exp_err_q.push_back(exp_err);
        clear_counts();
        sd_if.iAddr = addr;
        sd_if.iCall = call;
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (sd_if.oDone) begin
                ok = 1'b1;
                break;
            end
        end
        sd_if.iCall = 2'b00;
        chk("op_done_in_budget", 64'(ok), 64'd1);
        @(negedge clk);
    endtask

    initial begin : main
        int done_before;
        bit reached;
        rst         = 1'b1;
        sd_if.iCall = 2'b00;
        sd_if.iAddr = 32'h0;
        cmd0_ff     = 1'b0;
        r17         = 8'h00;
        token_after = 5;
        didx        = 0;
        n_done      = 0;
        clear_counts();
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Good init: CMD0 -> 01, CMD1 -> 01, 01, 00
        cmd1_seq = '{8'h01, 8'h01, 8'h00};
        run_op(2'b10, 32'h0, 1'b0);
        chk("init_dummy_bytes", 64'(hi_before_cmd0), 64'd10);
        chk("init_cmd0_count",  64'(n_cmd0), 64'd1);
        chk("init_cmd1_count",  64'(n_cmd1), 64'd3);
        chk("init_cmd_ncs_hi",  64'(n_cmd_ncs_hi), 64'd0);
        chk("init_hi_bytes",    64'(n_hi_bytes), 64'd11);
        chk("init_ncs_end",     64'(sd_if.SD_NCS), 64'd1);

        // Init with CMD0 never answered
        cmd0_ff = 1'b1;
        run_op(2'b10, 32'h0, 1'b1);
        chk("init_fail_cmd0_count", 64'(n_cmd0), 64'd100);
        chk("init_fail_cmd1_count", 64'(n_cmd1), 64'd0);
        chk("init_fail_hi_bytes",   64'(n_hi_bytes), 64'd11);
        chk("init_fail_ncs_end",    64'(sd_if.SD_NCS), 64'd1);
        cmd0_ff = 1'b0;

        // Good read of sector 3, token after 5 polls
        r17 = 8'h00; token_after = 5;
        run_op(2'b01, 32'd3, 1'b0);
        chk("read_faddr",    64'(last_faddr), 64'h51_00000600_FF);
        chk("read_en_count", 64'(n_en), 64'd512);
        chk("read_polls",    64'(n_polls), 64'd6);
        chk("read_crc",      64'(n_crc), 64'd2);
        chk("read_trailing", 64'(n_hi_bytes), 64'd1);
        chk("read_sb_empty", 64'(exp_data_q.size()), 64'd0);

        // Read rejected by the card
        r17 = 8'h05;
        run_op(2'b01, 32'd3, 1'b1);
        chk("r1bad_polls", 64'(n_polls), 64'd0);
        chk("r1bad_en",    64'(n_en), 64'd0);
        chk("r1bad_cmd17", 64'(n_cmd17), 64'd1);

        // Read that never sees a start token
        r17 = 8'h00; token_after = -1;
        run_op(2'b01, 32'd9, 1'b1);
        chk("notoken_polls", 64'(n_polls), 64'd1000);
        chk("notoken_en",    64'(n_en), 64'd0);

        // Both request bits set: init wins
        token_after = 5;
        cmd1_seq.delete();
        run_op(2'b11, 32'd3, 1'b0);
        chk("both_first_cmd", 64'(first_cmd), 64'h40);
        chk("both_cmd17",     64'(n_cmd17), 64'd0);
        chk("both_cmd1",      64'(n_cmd1), 64'd1);

        // Reset in the middle of the data phase
        token_after = 2;
        clear_counts();
        sd_if.iAddr = 32'd3;
        sd_if.iCall = 2'b01;
        reached = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (n_en >= 200) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reset_reached_byte200", 64'(reached), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        sd_if.iCall = 2'b00;
        @(negedge clk);
        chk_reset_outputs();
        done_before = n_done;
        repeat (3) @(negedge clk);
        exp_data_q.delete();
        phase = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_done_after_reset", 64'(n_done), 64'(done_before));

        // Fresh read after the reset
        token_after = 3;
        run_op(2'b01, 32'd7, 1'b0);
        chk("fresh_en_count", 64'(n_en), 64'd512);
        chk("fresh_faddr",    64'(last_faddr), 64'h51_00000E00_FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
